// File: rtl/msg_s2p_framer.sv
// Serial-to-parallel message framer: MSB-first deserialiser, frame word indexing and a 2-entry output FIFO.
// Optional macro WORD_PARITY_EN adds a word_par output (XOR of the head word) stored per FIFO entry.
module msg_s2p_framer #(
  parameter int N    = 32,
  parameter int KMEM = 32,
  localparam int IW  = $clog2(KMEM)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          msg,
  input  logic          datavalid,
  output logic [N-1:0]  word_out,
  output logic [IW-1:0] word_idx,
  output logic          sof,
  output logic          eof,
  output logic          word_valid,
  input  logic          word_ready,
  output logic          ovf,
`ifdef WORD_PARITY_EN
  output logic          word_par,
`endif
  output logic          busy
);

  // state | meaning
  // IDLE  | bit count is zero, no partial word held
  // SHIFT | partial word held, waiting for remaining bits
  typedef enum logic {IDLE, SHIFT} cap_state_t;

  localparam int CW = $clog2(N);

  cap_state_t      state_q, state_d;
  logic [CW-1:0]   bitcnt;
  logic [N-2:0]    shreg;
  logic [IW-1:0]   wcnt;
  logic [N-1:0]    new_word;
  logic            word_done;

  logic [N-1:0]    tail_word;
  logic [IW-1:0]   tail_idx;
  logic            tail_valid;
`ifdef WORD_PARITY_EN
  logic            tail_par;
`endif

  logic            pop, push, full_block;
  logic            head_load, head_sel_tail, tail_load;
  logic            tail_valid_d, word_valid_d;
  logic [N-1:0]    head_word_d;
  logic [IW-1:0]   head_idx_d;

  assign new_word  = {shreg, msg};
  assign word_done = datavalid && (bitcnt == CW'(N-1));
  assign busy      = (state_q == SHIFT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (datavalid) state_d = SHIFT;
      SHIFT:   if (word_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      if (datavalid) begin
        shreg  <= new_word[N-2:0];
        bitcnt <= word_done ? '0 : bitcnt + CW'(1);
      end
    end
  end

  // A pop frees a slot on the same edge, so only a full FIFO with no pop drops the word.
  always_comb begin
    pop           = word_valid & word_ready;
    full_block    = word_valid & tail_valid & ~pop;
    push          = word_done & ~full_block;
    head_load     = 1'b0;
    head_sel_tail = 1'b0;
    tail_load     = 1'b0;
    tail_valid_d  = tail_valid;
    word_valid_d  = word_valid;
    if (pop) begin
      if (tail_valid) begin
        head_load     = 1'b1;
        head_sel_tail = 1'b1;
        tail_load     = push;
        tail_valid_d  = push;
      end else begin
        head_load    = push;
        word_valid_d = push;
      end
    end else if (push) begin
      if (!word_valid) begin
        head_load    = 1'b1;
        word_valid_d = 1'b1;
      end else begin
        tail_load    = 1'b1;
        tail_valid_d = 1'b1;
      end
    end
    head_word_d = head_sel_tail ? tail_word : new_word;
    head_idx_d  = head_sel_tail ? tail_idx  : wcnt;
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      word_out   <= '0;
      word_idx   <= '0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      word_valid <= 1'b0;
      tail_word  <= '0;
      tail_idx   <= '0;
      tail_valid <= 1'b0;
      wcnt       <= '0;
      ovf        <= 1'b0;
`ifdef WORD_PARITY_EN
      word_par   <= 1'b0;
      tail_par   <= 1'b0;
`endif
    end else begin
      word_valid <= word_valid_d;
      tail_valid <= tail_valid_d;
      if (head_load) begin
        word_out <= head_word_d;
        word_idx <= head_idx_d;
        sof      <= (head_idx_d == '0);
        eof      <= (head_idx_d == IW'(KMEM-1));
`ifdef WORD_PARITY_EN
        word_par <= head_sel_tail ? tail_par : ^new_word;
`endif
      end
      if (tail_load) begin
        tail_word <= new_word;
        tail_idx  <= wcnt;
`ifdef WORD_PARITY_EN
        tail_par  <= ^new_word;
`endif
      end
      if (push)
        wcnt <= (wcnt == IW'(KMEM-1)) ? '0 : wcnt + IW'(1);
      if (word_done && full_block)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_msg_s2p_framer.sv
// Bench for msg_s2p_framer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_msg_s2p_framer;
  localparam int N    = 32;
  localparam int KMEM = 32;
  localparam int IW   = $clog2(KMEM);

  logic          clk_in = 1'b0;
  logic          rst = 1'b0;
  logic          msg = 1'b0;
  logic          datavalid = 1'b0;
  logic          word_ready = 1'b1;
  logic [N-1:0]  word_out;
  logic [IW-1:0] word_idx;
  logic          sof, eof, word_valid, ovf, busy;
`ifdef WORD_PARITY_EN
  logic          word_par;
`endif

  msg_s2p_framer #(.N(N), .KMEM(KMEM)) dut (
    .clk_in(clk_in), .rst(rst), .msg(msg), .datavalid(datavalid),
    .word_out(word_out), .word_idx(word_idx), .sof(sof), .eof(eof),
    .word_valid(word_valid), .word_ready(word_ready), .ovf(ovf),
`ifdef WORD_PARITY_EN
    .word_par(word_par),
`endif
    .busy(busy));

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue with pop-before-push, sticky overflow, displayed head holds when empty.
  logic [N-1:0] m_qw[$];
  int           m_qi[$];
  logic [N-1:0] m_bits;
  int           m_nb, m_wc;
  logic         m_ovf, started = 1'b0;
  logic [N-1:0] e_word;
  int           e_idx;
  logic         e_sof, e_eof;

  always @(posedge clk_in) begin
    if (!rst) begin
      m_qw.delete(); m_qi.delete();
      m_bits = '0; m_nb = 0; m_wc = 0; m_ovf = 1'b0;
      e_word = '0; e_idx = 0; e_sof = 1'b0; e_eof = 1'b0;
    end else begin
      if (m_qw.size() > 0 && word_ready) begin
        void'(m_qw.pop_front());
        void'(m_qi.pop_front());
      end
      if (datavalid) begin
        m_bits = {m_bits[N-2:0], msg};
        m_nb++;
        if (m_nb == N) begin
          m_nb = 0;
          if (m_qw.size() < 2) begin
            m_qw.push_back(m_bits);
            m_qi.push_back(m_wc);
            m_wc = (m_wc + 1) % KMEM;
          end else m_ovf = 1'b1;
        end
      end
      if (m_qw.size() > 0) begin
        e_word = m_qw[0]; e_idx = m_qi[0];
        e_sof = (e_idx == 0); e_eof = (e_idx == KMEM-1);
      end
    end
    started = 1'b1;
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("m_valid", word_valid, m_qw.size() > 0);
      chk("m_word", word_out, e_word);
      chk("m_idx", word_idx, e_idx);
      chk("m_sof", sof, e_sof);
      chk("m_eof", eof, e_eof);
      chk("m_ovf", ovf, m_ovf);
      chk("m_busy", busy, m_nb != 0);
`ifdef WORD_PARITY_EN
      chk("m_par", word_par, ^e_word);
`endif
    end
  end

  // Log of words the consumer accepted (actual values, compared to literals later)
  logic [N-1:0] lg_w[$];
  int           lg_i[$];
  logic         lg_sof[$], lg_eof[$];
  always @(negedge clk_in) begin
    if (rst && word_valid && word_ready) begin
      lg_w.push_back(word_out); lg_i.push_back(int'(word_idx));
      lg_sof.push_back(sof); lg_eof.push_back(eof);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = N-1; i >= 0; i--) begin
      msg = w[i]; datavalid = 1'b1;
      tick();
    end
  endtask

  task automatic do_reset();
    datavalid = 1'b0; rst = 1'b0;
    tick(); tick();
    lg_w.delete(); lg_i.delete(); lg_sof.delete(); lg_eof.delete();
    rst = 1'b1;
  endtask

  logic [N-1:0] wt[0:32];

  initial begin
    #1000000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    wt[0] = 32'hD9DA7BEA;
    for (int k = 1; k < 33; k++) wt[k] = wt[k-1] * 32'd1664525 + 32'd1013904223;
    wt[31] = 32'hF9AC1751;
    wt[32] = 32'h1A31D8AB ^ 32'h1;

    // 1: reset state
    do_reset(); word_ready = 1'b1;
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_word", word_out, 32'h0);
    chk("rst_idx", word_idx, 0);
    chk("rst_sof_eof_ovf_busy", {sof, eof, ovf, busy}, 4'b0000);

    // 2: single word
    send_word(32'hD9DA7BEA);
    datavalid = 1'b0;
    chk("t2_valid", word_valid, 1'b1);
    chk("t2_word", word_out, 32'hD9DA7BEA);
    chk("t2_idx_sof_eof", {word_idx, sof, eof}, {5'd0, 1'b1, 1'b0});
    tick();
    chk("t2_popped", word_valid, 1'b0);

    // 3: full frame back-to-back plus wrap
    do_reset();
    for (int k = 0; k < 33; k++) send_word(wt[k]);
    datavalid = 1'b0;
    tick(); tick();
    chk("t3_count", lg_w.size(), 33);
    if (lg_w.size() >= 33) begin
      chk("t3_w31", lg_w[31], 32'hF9AC1751);
      chk("t3_i31_eof", {lg_i[31][7:0], lg_sof[31], lg_eof[31]}, {8'd31, 1'b0, 1'b1});
      chk("t3_w32", lg_w[32], 32'h1A31D8AA);
      chk("t3_i32_sof", {lg_i[32][7:0], lg_sof[32], lg_eof[32]}, {8'd0, 1'b1, 1'b0});
    end
    chk("t3_ovf", ovf, 1'b0);

    // 4: overflow
    do_reset(); word_ready = 1'b0;
    send_word(32'h11112222); send_word(32'h33334444); send_word(32'h55556666);
    datavalid = 1'b0;
    tick();
    chk("t4_ovf", ovf, 1'b1);
    chk("t4_head", word_out, 32'h11112222);
    word_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("t4_drained", lg_w.size(), 2);
    if (lg_w.size() >= 2) begin
      chk("t4_d0", {lg_w[0], lg_i[0][7:0]}, {32'h11112222, 8'd0});
      chk("t4_d1", {lg_w[1], lg_i[1][7:0]}, {32'h33334444, 8'd1});
    end
    send_word(32'h77778888);
    datavalid = 1'b0;
    chk("t4_next_idx", {word_valid, word_idx}, {1'b1, 5'd2});
    chk("t4_ovf_sticky", ovf, 1'b1);

    // 5: datavalid toggling
    do_reset();
    for (int i = N-1; i >= 0; i--) begin
      msg = 1'(32'h855C5C5C >> i); datavalid = 1'b1;
      tick();
      if (i == N-1) chk("t5_busy_first", busy, 1'b1);
      datavalid = 1'b0;
      if (i == 0) begin
        chk("t5_word", {word_valid, word_out}, {1'b1, 32'h855C5C5C});
        chk("t5_busy_done", busy, 1'b0);
      end else begin
        tick();
        if (i == 1) chk("t5_busy_before", busy, 1'b1);
      end
    end
    tick();

    // 6: reset mid-word
    for (int i = 0; i < 17; i++) begin
      msg = 1'(i % 3 == 0); datavalid = 1'b1;
      tick();
    end
    datavalid = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_busy_cleared", busy, 1'b0);
    send_word(32'h50ED00C4);
    datavalid = 1'b0;
    chk("t6_word", {word_valid, word_out}, {1'b1, 32'h50ED00C4});
    chk("t6_idx_sof_ovf", {word_idx, sof, ovf}, {5'd0, 1'b1, 1'b0});
`ifdef WORD_PARITY_EN
    chk("t6_par", word_par, 1'b1);
`endif
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
